i2c_target: RTL and testbench

//  I2C target (responder) for the tag's serial test/config port; the other end of our I2C initiator.
//  - Watches externally driven SCL/SDA and oversamples them on clk.
//  - Acknowledges its own 7-bit address.
//  - Delivers written bytes to the core and returns core-supplied bytes on reads.
//  - Open-drain: only ever pulls SDA low; never drives SCL, so no clock stretching.

---
 rtl/i2c_target_if.sv | 23 ++
 rtl/i2c_target.sv | 190 +++++++++++++++++++
 tb/tb_i2c_target.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// Bus and core-side signals of the I2C target: pin levels in, open-drain enable out,
// plus the byte-wide receive/transmit handshake towards the core.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;
    logic       addr_match;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, addr_match
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, addr_match
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target for the serial test/config port: oversamples SCL/SDA, answers one 7-bit
// address, hands written bytes to the core and shifts core bytes out on reads.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    i2c_target_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_S,
        AACK,
        WRITE,
        WACK,
        READ,
        RACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s, sda_s;
    logic                   scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state;
    logic [7:0] shreg;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       ack_ok;
    logic       sda_oe_r;
    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic       tx_req_r;
    logic       busy_r;
    logic       addr_match_r;

    // Synchroniser chain and 1-clk delayed copies; reset to the idle-bus level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  scl_d & ~sda_s &  sda_d;
    assign stop_det  =  scl_s &  scl_d &  sda_s & ~sda_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            shreg        <= 8'h00;
            bit_cnt      <= 4'd0;
            rw           <= 1'b0;
            ack_ok       <= 1'b0;
            sda_oe_r     <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            tx_req_r     <= 1'b0;
            busy_r       <= 1'b0;
            addr_match_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            // Bus conditions override any bit action in the same clock.
            if (start_det) begin
                state        <= ADDR_S;
                bit_cnt      <= 4'd0;
                ack_ok       <= 1'b0;
                sda_oe_r     <= 1'b0;
                busy_r       <= 1'b1;
                addr_match_r <= 1'b0;
            end else if (stop_det) begin
                state        <= IDLE;
                ack_ok       <= 1'b0;
                sda_oe_r     <= 1'b0;
                busy_r       <= 1'b0;
                addr_match_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: sda_oe_r <= 1'b0;
                    ADDR_S: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            // Address 0 is the general call and is never claimed.
                            if (shreg[7:1] == ADDR && shreg[7:1] != 7'd0) begin
                                sda_oe_r     <= 1'b1;
                                addr_match_r <= 1'b1;
                                rw           <= shreg[0];
                                tx_req_r     <= shreg[0];
                                state        <= AACK;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    AACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shreg    <= bus.tx_data;
                                sda_oe_r <= ~bus.tx_data[7];
                                bit_cnt  <= 4'd1;
                                state    <= READ;
                            end else begin
                                sda_oe_r <= 1'b0;
                                bit_cnt  <= 4'd0;
                                state    <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_data_r  <= {shreg[6:0], sda_s};
                                rx_valid_r <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe_r <= 1'b1;
                            state    <= WACK;
                        end
                    end
                    WACK: begin
                        if (scl_fall) begin
                            sda_oe_r <= 1'b0;
                            bit_cnt  <= 4'd0;
                            state    <= WRITE;
                        end
                    end
                    READ: begin
                        // bit_cnt counts bits already placed on the bus.
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_r <= 1'b0;
                                ack_ok   <= 1'b0;
                                state    <= RACK;
                            end else begin
                                sda_oe_r <= ~shreg[6];
                                shreg    <= {shreg[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                tx_req_r <= 1'b1;
                                ack_ok   <= 1'b1;
                            end else begin
                                sda_oe_r <= 1'b0;
                                state    <= IDLE;
                            end
                        end else if (scl_fall && ack_ok) begin
                            ack_ok   <= 1'b0;
                            shreg    <= bus.tx_data;
                            sda_oe_r <= ~bus.tx_data[7];
                            bit_cnt  <= 4'd1;
                            state    <= READ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.sda_oe     = sda_oe_r;
    assign bus.rx_data    = rx_data_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.tx_req     = tx_req_r;
    assign bus.busy       = busy_r;
    assign bus.addr_match = addr_match_r;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged initiator on an open-drain SDA model.
module tb_i2c_target;

    localparam int Q = 4;  // clk cycles per quarter SCL period

    logic clk;
    logic reset;
    logic scl_m;
    logic sda_m;

    i2c_target_if bus ();

    i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int rx_cnt   = 0;
    int tx_cnt   = 0;
    logic oe_seen = 1'b0;
    logic am_seen = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_valid) rx_cnt++;
        if (bus.tx_req) tx_cnt++;
        if (bus.sda_oe) oe_seen = 1'b1;
        if (bus.addr_match) am_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic clk_bit(input logic b, output logic seen);
        sda_m = b;    wq();
        scl_m = 1'b1; wq();
        seen  = bus.sda_in;
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;
        int         rx0, tx0;

        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        bus.tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_tx_req", bus.tx_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr_match", bus.addr_match, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 1: write 0xA5 to 0x42
        rx0 = rx_cnt;
        i2c_start();
        check("t1_busy_start", bus.busy, 1);
        write_byte(8'h84, ack);
        check("t1_addr_ack", ack, 0);
        check("t1_addr_match", bus.addr_match, 1);
        write_byte(8'hA5, ack);
        check("t1_data_ack", ack, 0);
        check("t1_rx_data", bus.rx_data, 8'hA5);
        check("t1_rx_count", rx_cnt - rx0, 1);
        i2c_stop();
        check("t1_busy_stop", bus.busy, 0);
        check("t1_am_stop", bus.addr_match, 0);

        // 2: read two bytes, ACK then NACK
        tx0 = tx_cnt;
        bus.tx_data = 8'h3C;
        i2c_start();
        write_byte(8'h85, ack);
        check("t2_addr_ack", ack, 0);
        bus.tx_data = 8'hC3;
        read_byte(1'b0, rd);
        check("t2_byte0", rd, 8'h3C);
        read_byte(1'b1, rd);
        check("t2_byte1", rd, 8'hC3);
        i2c_stop();
        check("t2_tx_req_count", tx_cnt - tx0, 2);
        check("t2_busy_stop", bus.busy, 0);

        // 3: foreign address is ignored
        rx0 = rx_cnt;
        oe_seen = 1'b0;
        am_seen = 1'b0;
        i2c_start();
        write_byte(8'h86, ack);
        check("t3_addr_nack", ack, 1);
        write_byte(8'h55, ack);
        check("t3_data_nack", ack, 1);
        i2c_stop();
        check("t3_oe_seen", oe_seen, 0);
        check("t3_am_seen", am_seen, 0);
        check("t3_rx_count", rx_cnt - rx0, 0);

        // 4: write then repeated START into a read
        i2c_start();
        write_byte(8'h84, ack);
        check("t4_waddr_ack", ack, 0);
        write_byte(8'h10, ack);
        check("t4_wdata_ack", ack, 0);
        check("t4_rx_data", bus.rx_data, 8'h10);
        bus.tx_data = 8'h99;
        i2c_start();
        check("t4_busy_sr", bus.busy, 1);
        check("t4_am_sr", bus.addr_match, 0);
        write_byte(8'h85, ack);
        check("t4_raddr_ack", ack, 0);
        read_byte(1'b1, rd);
        check("t4_rdata", rd, 8'h99);
        check("t4_busy_pre_stop", bus.busy, 1);
        i2c_stop();
        check("t4_busy_stop", bus.busy, 0);

        // 5: reset while the target is pulling SDA for a 0 read bit
        bus.tx_data = 8'h3C;
        i2c_start();
        write_byte(8'h85, ack);
        check("t5_addr_ack", ack, 0);
        check("t5_driving_zero", bus.sda_oe, 1);
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_sda_oe", bus.sda_oe, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_am", bus.addr_match, 0);
        check("t5_rst_rx_data", bus.rx_data, 0);
        reset = 1'b1;
        sda_m = 1'b1;
        wq();
        i2c_start();
        write_byte(8'h84, ack);
        check("t5_after_ack", ack, 0);
        write_byte(8'h5A, ack);
        check("t5_after_rx", bus.rx_data, 8'h5A);
        i2c_stop();

        // 6: STOP in the middle of a write byte
        i2c_start();
        write_byte(8'h84, ack);
        check("t6_addr_ack", ack, 0);
        rx0 = rx_cnt;
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        clk_bit(1'b1, s);
        clk_bit(1'b0, s);
        i2c_stop();
        check("t6_rx_count", rx_cnt - rx0, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_am", bus.addr_match, 0);
        check("t6_sda_oe", bus.sda_oe, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
